// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-port memory.
// Data has default priority, and a run-length counter hands priority to a waiting fetch.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_valid_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic                  i_ready_o,
    output logic                  i_rvalid_o,
    input  logic                  d_valid_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_ready_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t           state, state_next;
    logic [LAT_W-1:0] lat_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic             src_data;
    logic             fetch_pri;
    logic             grant_i, grant_d;

    assign fetch_pri = (run_cnt == RUN_MAX);
    assign i_ready_o = grant_i;
    assign d_ready_o = grant_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Readies are gated by reset so nothing is accepted while it is held.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst_i) begin
                    if (d_valid_i && (!i_valid_i || !fetch_pri)) begin
                        grant_d = 1'b1;
                    end else if (i_valid_i) begin
                        grant_i = 1'b1;
                    end
                end
                if (grant_i || grant_d) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_cnt <= '0;
        end else if (grant_d) begin
            if (!i_valid_i) begin
                run_cnt <= '0;
            end else if (run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
        end else if (grant_i) begin
            run_cnt <= '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_cnt     <= '0;
            src_data    <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
            i_rvalid_o  <= 1'b0;
            d_rvalid_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            mem_en_o   <= 1'b0;
            i_rvalid_o <= 1'b0;
            d_rvalid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                        src_data    <= 1'b1;
                        lat_cnt     <= LAT_LOAD;
                        busy_o      <= 1'b1;
                    end else if (grant_i) begin
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= i_addr_i;
                        mem_wdata_o <= '0;
                        src_data    <= 1'b0;
                        lat_cnt     <= LAT_LOAD;
                        busy_o      <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == '0) begin
                        rdata_o    <= mem_we_o ? '0 : mem_rdata_i;
                        d_rvalid_o <= src_data;
                        i_rvalid_o <= !src_data;
                        mem_we_o   <= 1'b0;
                        busy_o     <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Random and directed checks of mem_arbiter against a cycle-accurate transaction model.
module tb_mem_arbiter;

    localparam int L      = 2;
    localparam int MAXRUN = 4;

    logic        clk, rst;
    logic        i_valid, i_ready, i_rvalid;
    logic [31:0] i_addr;
    logic        d_valid, d_we, d_ready, d_rvalid;
    logic [31:0] d_addr, d_wdata, rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_i_ready, b_i_rvalid, b_d_valid, b_d_ready, b_d_rvalid;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_d_addr, b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    logic [31:0] rom [16];
    int          age;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    // reference model state
    bit          have_txn;
    int          t_acc, free_at, run;
    bit          t_d, t_we;
    logic [31:0] t_addr, t_wdata, t_exp, last_rdata;
    bit          last_gi, last_gd;
    bit          gq[$];
    int          gcyc[$];
    int          p_i, p_d;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L), .MAX_DATA_RUN(MAXRUN)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .i_valid_i(i_valid), .i_addr_i(i_addr), .i_ready_o(i_ready), .i_rvalid_o(i_rvalid),
        .d_valid_i(d_valid), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ready_o(d_ready), .d_rvalid_o(d_rvalid), .rdata_o(rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .MAX_DATA_RUN(MAXRUN)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .i_valid_i(1'b0), .i_addr_i(32'h0), .i_ready_o(b_i_ready), .i_rvalid_o(b_i_rvalid),
        .d_valid_i(b_d_valid), .d_we_i(1'b0), .d_addr_i(b_d_addr), .d_wdata_i(32'h0),
        .d_ready_o(b_d_ready), .d_rvalid_o(b_d_rvalid), .rdata_o(b_rdata),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
        .mem_rdata_i(b_mem_rdata), .busy_o(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns valid data only in the L-th cycle after the strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) age <= 0;
        else if (mem_en) age <= 2;
        else if (age != 0) age <= age + 1;
    end
    assign mem_rdata   = ((mem_en ? 1 : age) == L) ? rom[mem_addr[5:2]] : 32'hBADBAD00;
    assign b_mem_rdata = b_mem_en ? rom[b_mem_addr[5:2]] : 32'hBADBAD00;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        have_txn   = 1'b0;
        free_at    = 0;
        run        = 0;
        last_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b1;
        d_valid = 1'b1;
        #1;
        check_eq("rst_i_ready", i_ready, 1'b0);
        check_eq("rst_d_ready", d_ready, 1'b0);
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_en", mem_en, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_i_rvalid", i_rvalid, 1'b0);
        check_eq("rst_d_rvalid", d_rvalid, 1'b0);
        i_valid = 1'b0;
        d_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One clock: check outputs against the model, predict the grant, then update requesters.
    task automatic step();
        bit in_wait, resp, gi, gd, fp;
        @(negedge clk);
        in_wait = have_txn && cyc >= t_acc + 1 && cyc <= t_acc + L;
        resp    = have_txn && cyc == t_acc + L + 1;
        check_eq("busy", busy, in_wait);
        check_eq("mem_en", mem_en, have_txn && cyc == t_acc + 1);
        check_eq("mem_we", mem_we, in_wait && t_we);
        if (in_wait) begin
            check_eq("mem_addr", mem_addr, t_addr);
            check_eq("mem_wdata", mem_wdata, t_wdata);
        end
        check_eq("i_rvalid", i_rvalid, resp && !t_d);
        check_eq("d_rvalid", d_rvalid, resp && t_d);
        if (resp) last_rdata = t_exp;
        check_eq("rdata", rdata, last_rdata);

        gi = 1'b0;
        gd = 1'b0;
        if (cyc >= free_at) begin
            fp = (run == MAXRUN);
            gd = d_valid && (!i_valid || !fp);
            gi = i_valid && !gd;
        end
        check_eq("i_ready", i_ready, gi);
        check_eq("d_ready", d_ready, gd);
        if (gi || gd) begin
            have_txn = 1'b1;
            t_acc    = cyc;
            t_d      = gd;
            t_we     = gd && d_we;
            t_addr   = gd ? d_addr : i_addr;
            t_wdata  = gd ? d_wdata : 32'h0;
            t_exp    = t_we ? 32'h0 : rom[t_addr[5:2]];
            free_at  = cyc + L + 1;
            gq.push_back(gd);
            gcyc.push_back(cyc);
        end
        if (gd) run = i_valid ? ((run < MAXRUN) ? run + 1 : run) : 0;
        if (gi) run = 0;
        last_gi = gi;
        last_gd = gd;

        @(posedge clk);
        #1;
        cyc++;
        if (gi) i_valid = 1'b0;
        if (gd) d_valid = 1'b0;
        if (!i_valid && $urandom_range(99) < p_i) begin
            i_valid = 1'b1;
            i_addr  = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_valid && $urandom_range(99) < p_d) begin
            d_valid = 1'b1;
            d_we    = 1'($urandom_range(1));
            d_addr  = $urandom & 32'hFFFF_FFFC;
            d_wdata = $urandom;
        end
    endtask

    task automatic wait_grants(input int n, input string tag);
        int k;
        k = 0;
        while (gq.size() < n && k < 200) begin
            step();
            k++;
        end
        check_eq(tag, gq.size(), n);
    endtask

    initial begin
        logic [9:0]  order, exp_order;
        logic [31:0] b_addrs [3];
        bit          exp_rdy [7];
        bit          exp_rv  [7];
        int          acc_k, rsp_k;

        for (int i = 0; i < 16; i++) rom[i] = $urandom;
        rom[0] = 32'hDEADBEEF;
        rst = 1'b1;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        b_d_valid = 1'b0; b_d_addr = '0;
        p_i = 0; p_d = 0;
        model_reset();
        do_reset();

        // single fetch
        i_valid = 1'b1; i_addr = 32'h40;
        step();
        check_eq("fetch_ready_c0", last_gi, 1'b1);
        repeat (4) step();

        // single store
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h12345678;
        step();
        check_eq("store_ready_c0", last_gd, 1'b1);
        repeat (4) step();

        // simultaneous requests with run_cnt at zero
        gq.delete(); gcyc.delete();
        i_valid = 1'b1; i_addr = 32'h44;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h48; d_wdata = 32'h0;
        wait_grants(2, "simul_timeout");
        if (gq.size() == 2) begin
            check_eq("simul_first_is_data", gq[0], 1'b1);
            check_eq("simul_second_is_fetch", gq[1], 1'b0);
            check_eq("simul_fetch_gap", gcyc[1] - gcyc[0], L + 1);
        end
        repeat (4) step();

        // starvation guard
        gq.delete(); gcyc.delete();
        p_i = 100; p_d = 100;
        i_valid = 1'b1; i_addr = 32'h80;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h84; d_wdata = 32'h0;
        wait_grants(10, "starve_timeout");
        order = '0;
        for (int i = 0; i < 10 && i < gq.size(); i++) order = {order[8:0], gq[i]};
        exp_order = 10'b1111011110;
        check_eq("starve_order", order, exp_order);

        // random traffic
        p_i = 40; p_d = 60;
        repeat (400) step();
        p_i = 0; p_d = 0;
        repeat (24) step();

        // reset in the first WAIT cycle of a store
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h10C; d_wdata = 32'hA5A5_5A5A;
        step();
        check_eq("rstwait_grant", last_gd, 1'b1);
        check_eq("rstwait_pre_mem_we", mem_we, 1'b1);
        check_eq("rstwait_pre_mem_en", mem_en, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rstwait_async_mem_we", mem_we, 1'b0);
        check_eq("rstwait_async_mem_en", mem_en, 1'b0);
        do_reset();
        repeat (L + 3) step();
        check_eq("rstwait_busy_after", busy, 1'b0);

        // back-to-back loads with MEM_LATENCY=1
        b_addrs[0] = 32'h04; b_addrs[1] = 32'h08; b_addrs[2] = 32'h0C;
        exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_rv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        acc_k = 0; rsp_k = 0;
        b_d_valid = 1'b1; b_d_addr = b_addrs[0];
        for (int c = 0; c < 7; c++) begin
            bit rdy;
            @(negedge clk);
            rdy = b_d_ready;
            check_eq("b2b_ready", rdy, exp_rdy[c]);
            check_eq("b2b_rvalid", b_d_rvalid, exp_rv[c]);
            if (b_d_rvalid && rsp_k < 3) begin
                check_eq("b2b_rdata", b_rdata, rom[b_addrs[rsp_k][5:2]]);
                rsp_k++;
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                acc_k++;
                if (acc_k >= 3) b_d_valid = 1'b0;
                else b_d_addr = b_addrs[acc_k];
            end
        end
        check_eq("b2b_responses", rsp_k, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port `main_memory` between the instruction-fetch path and the load/store path once both are routed through one memory instance. Each side uses a valid/ready request handshake. Data requests win by default, and a run-length counter stops fetch from being starved. A fixed-latency sequencer drives the memory port and returns read data to the requester with a one-cycle response pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: word width.
- `MEM_LATENCY`, default 2: cycles from memory issue to valid `mem_rdata_i`. Legal range is ≥1.
- `MAX_DATA_RUN`, default 4: consecutive data grants allowed while fetch waits. Legal range is ≥1.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `i_valid_i`  in  1  fetch request valid.
- `i_addr_i`  in  ADDR_WIDTH  fetch address.
- `i_ready_o`  out  1  fetch request accepted this cycle.
- `i_rvalid_o`  out  1  fetch response pulse.
- `d_valid_i`  in  1  data request valid.
- `d_we_i`  in  1  data request is a store.
- `d_addr_i`  in  ADDR_WIDTH  data address.
- `d_wdata_i`  in  DATA_WIDTH  store value.
- `d_ready_o`  out  1  data request accepted this cycle.
- `d_rvalid_o`  out  1  data response pulse; also pulses for stores.
- `rdata_o`  out  DATA_WIDTH  response word, shared by both sides.
- `mem_en_o`  out  1  memory access strobe.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  ADDR_WIDTH  memory address.
- `mem_wdata_o`  out  DATA_WIDTH  memory write value.
- `mem_rdata_i`  in  DATA_WIDTH  memory read value.
- `busy_o`  out  1  high while not IDLE.

## Operation
- **States:** IDLE and WAIT.
- **Handshakes:** a requester holds valid and payload stable until it sees its ready. Acceptance happens when valid and ready are both high at a rising edge. Ready outputs are combinational and are only high in IDLE.
- **Arbitration in IDLE:**
  - Fetch gets priority (`fetch_pri`) when `run_cnt == MAX_DATA_RUN`. Otherwise data has priority.
  - With both valid, the priority side gets ready. With one valid, that side gets ready.
- **`run_cnt` update (saturating at `MAX_DATA_RUN`):**
  - Increments on a data grant made while `i_valid_i` is high.
  - Clears on any fetch grant.
  - Clears on a data grant made while `i_valid_i` is low.
- **On acceptance:**
  - Latch address, write enable, write data (zero for fetch) and the source into `mem_*` registers.
  - Load `lat_cnt = MEM_LATENCY-1` and go to WAIT.
- **WAIT:**
  - `mem_en_o` is high in the first WAIT cycle only.
  - `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are held for all of WAIT.
  - `lat_cnt` decrements each cycle.
  - When `lat_cnt == 0`, the edge does three things:
    - Captures `mem_rdata_i` into `rdata_o` for loads and fetches, or 0 for stores.
    - Sets the source's rvalid for the next cycle.
    - Returns the FSM to IDLE.
- **Responses:**
  - rvalid is a one-cycle pulse with no backpressure.
  - `rdata_o` holds its value until the next capture.
  - `mem_we_o` returns to 0 on leaving WAIT.
- **Reset:**
  - IDLE; `run_cnt`, `lat_cnt` and every registered output are 0.
  - `i_ready_o` and `d_ready_o` are 0 while reset is asserted.
  - An access in flight when reset arrives is dropped: no rvalid follows, and `mem_en_o` and `mem_we_o` are forced low immediately.

## Timing
- Handshake in cycle C0.
- WAIT occupies C1..C(MEM_LATENCY), with `mem_en_o` high in C1.
- rvalid and new `rdata_o` appear in C(MEM_LATENCY+1). IDLE is in the same cycle, so a new acceptance is possible then.
- Request-to-response latency is MEM_LATENCY+1 cycles. Peak throughput is one access per MEM_LATENCY+1 cycles.
- With MEM_LATENCY=1, WAIT lasts one cycle, and `mem_en_o` and capture fall in the same cycle.
- A request arriving during WAIT sees ready low and must hold until IDLE.
- A new handshake in the same cycle as an rvalid pulse is legal. The two events are independent.
- `busy_o` = (state == WAIT), registered.

## Test plan
- **Reset:** assert `rst_i` mid-WAIT with a store in progress. Required: `mem_we_o` and `mem_en_o` go to 0 asynchronously; `busy_o`=0 after release; no `d_rvalid_o` is ever seen.
- **Single fetch, MEM_LATENCY=2:** `i_valid_i`=1, `i_addr_i`=0x40, memory returns 0xDEADBEEF. Required:
  - `i_ready_o` high in C0.
  - `mem_en_o`=1 in C1 with `mem_addr_o`=0x40.
  - `i_rvalid_o`=1 and `rdata_o`=0xDEADBEEF in C3.
- **Store:** `d_we_i`=1, `d_addr_i`=0x100, `d_wdata_i`=0x12345678. Required: `mem_we_o`=1 with matching addr/wdata through WAIT; `d_rvalid_o` pulses in C3 with `rdata_o`=0.
- **Simultaneous requests, `run_cnt`=0:** both valid. Required: data is granted first; fetch is granted at the first IDLE after the data response.
- **Starvation, MAX_DATA_RUN=4:** fetch and data held valid continuously. Required: the grant order is D,D,D,D,I,D,D,D,D,I.
- **Back-to-back, MEM_LATENCY=1:** data valid continuously for 3 loads. Required: a response every 2 cycles; ready aligns with each rvalid cycle.
